// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory side of the multicycle datapath.
// Contents:
//   size_t  - access size encodings as carried on the 2-bit size field
//   state_t - store FSM states (IDLE -> CHECK -> WRITE -> FINISH)
//   BE_*    - byte-enable patterns for the two halfword lanes
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CHECK  = 2'b01,
        S_WRITE  = 2'b10,
        S_FINISH = 2'b11
    } state_t;

    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane alignment for 32-bit little-endian data memory.
// Ports:
//   size     in  2   access size (size_t encoding)
//   addr_lo  in  2   low two bits of the byte address
//   data     in  32  register value to be stored
//   wdata    out 32  value replicated into every lane the size could occupy
//   be       out 4   byte enables, bit i = byte lane i
//   misalign out 1   illegal size or address not aligned to the size
//   fits     out 1   data equals the sign extension of its low byte/half
// Pure function of its inputs so the load path can reuse it in reverse.
module store_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misalign,
    output logic        fits
);

    always_comb begin
        wdata    = 32'd0;
        be       = 4'b0000;
        misalign = 1'b0;
        fits     = 1'b0;
        case (size_t'(size))
            SZ_BYTE: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr_lo;
                // Sign extension of the low byte reproduces data only when
                // bits 31..7 are all copies of bit 7.
                fits  = (&data[31:7]) | ~(|data[31:7]);
            end
            SZ_HALF: begin
                wdata    = {2{data[15:0]}};
                be       = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
                misalign = addr_lo[0];
                fits     = (&data[31:15]) | ~(|data[31:15]);
            end
            SZ_WORD: begin
                wdata    = data;
                be       = BE_WORD;
                misalign = |addr_lo;
                fits     = 1'b1;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: captures a store request, aligns the data into the
// byte lanes of a 32-bit memory word and performs the write with a
// request/acknowledge handshake, aborting after ACK_TIMEOUT cycles.
// Ports:
//   clock, reset_n      clock, asynchronous active-low reset
//   start               store request, sampled only in IDLE
//   size, addr          access size (size_t) and byte address
//   store_data          register value to store
//   busy                high in every state except IDLE
//   mem_req             write request, high for the whole WRITE state
//   mem_addr, mem_wdata word-aligned address and lane-replicated data
//   mem_be              byte enables (0 outside a valid write)
//   mem_ack             memory accepted the write
//   done                one-cycle pulse when the operation ends
//   fault, fits         status, valid with done and held until next start
//   state_dbg           current FSM state (state_t encoding)
//
// Handshake: mem_req rises on entry to WRITE and stays high, with mem_addr,
// mem_wdata and mem_be stable, until the first cycle in which mem_ack is
// sampled high (the write completes in that cycle) or the timeout expires.
// mem_ack is ignored whenever mem_req is low.
module store_narrow_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              done,
    output logic              fault,
    output logic              fits,
    output logic [1:0]        state_dbg
);

    // Counter value in the last WRITE cycle before the abort.
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t state, state_nxt;

    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        tmo_cnt;

    logic [31:0] la_wdata;
    logic [3:0]  la_be;
    logic        la_misalign;
    logic        la_fits;
    logic        write_end;

    store_lane_align u_align (
        .size     (size_q),
        .addr_lo  (addr_q[1:0]),
        .data     (data_q),
        .wdata    (la_wdata),
        .be       (la_be),
        .misalign (la_misalign),
        .fits     (la_fits)
    );

    // Ack wins over a timeout landing in the same cycle; both leave WRITE.
    assign write_end = mem_ack | (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = la_misalign ? S_FINISH : S_WRITE;
            S_WRITE:  if (write_end) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            size_q    <= 2'b00;
            addr_q    <= '0;
            data_q    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
            tmo_cnt   <= 8'd0;
            fault     <= 1'b0;
            fits      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        size_q <= size;
                        addr_q <= addr;
                        data_q <= store_data;
                        fault  <= 1'b0;
                        fits   <= 1'b0;
                    end
                end
                S_CHECK: begin
                    mem_addr  <= {addr_q[ADDR_W-1:2], 2'b00};
                    mem_wdata <= la_wdata;
                    mem_be    <= la_misalign ? 4'b0000 : la_be;
                    fault     <= la_misalign;
                    fits      <= la_fits;
                    tmo_cnt   <= 8'd0;
                end
                S_WRITE: begin
                    if (write_end) begin
                        // Enables drop together with mem_req.
                        mem_be  <= 4'b0000;
                        tmo_cnt <= 8'd0;
                        fault   <= ~mem_ack;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_FINISH: begin
                    tmo_cnt <= 8'd0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign mem_req   = (state == S_WRITE);
    assign done      = (state == S_FINISH);
    assign state_dbg = state;

endmodule
